// File: rtl/cc_entry_tracker_pkg.sv
// cc_entry_tracker_pkg
//   Shared types for the Frogger goal-row entry tracker.
//   state_e  : round state (PLAY, WON, OVER)
//   result_e : outcome of judging one check strobe
//   count_width() : bit width needed to hold a count of 0..n inclusive
package cc_entry_tracker_pkg;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      WON  = 2'd1,
      OVER = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_ENTER = 2'd1,
      RES_LOSE  = 2'd2
   } result_e;

   function automatic int count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cc_entry_tracker_if.sv
// cc_entry_tracker_if
//   Bundles the game-side signals of the entry tracker.
//   master : the game logic (drives clear/check/entry/frog, reads results)
//   slave  : the tracker itself
//   clear_InHigh / check_InHigh : round restart and goal-row strobe
//   entryBUS / froggerBUS       : open-entry mask and frog column
//   enter/lose/win/gameover     : active-low result flags
//   filledBUS / fillCount       : occupied-entry mask and its popcount
interface cc_entry_tracker_if #(
   parameter int DW = 8
);
   import cc_entry_tracker_pkg::*;

   localparam int CW = count_width(DW);

   logic          CC_ENTRYTRACKER_clear_InHigh;
   logic          CC_ENTRYTRACKER_check_InHigh;
   logic [DW-1:0] CC_ENTRYTRACKER_entryBUS;
   logic [DW-1:0] CC_ENTRYTRACKER_froggerBUS;
   logic          CC_ENTRYTRACKER_enter_OutLow;
   logic          CC_ENTRYTRACKER_lose_OutLow;
   logic          CC_ENTRYTRACKER_win_OutLow;
   logic          CC_ENTRYTRACKER_gameover_OutLow;
   logic [DW-1:0] CC_ENTRYTRACKER_filledBUS;
   logic [CW-1:0] CC_ENTRYTRACKER_fillCount;

   modport master (
      output CC_ENTRYTRACKER_clear_InHigh,
      output CC_ENTRYTRACKER_check_InHigh,
      output CC_ENTRYTRACKER_entryBUS,
      output CC_ENTRYTRACKER_froggerBUS,
      input  CC_ENTRYTRACKER_enter_OutLow,
      input  CC_ENTRYTRACKER_lose_OutLow,
      input  CC_ENTRYTRACKER_win_OutLow,
      input  CC_ENTRYTRACKER_gameover_OutLow,
      input  CC_ENTRYTRACKER_filledBUS,
      input  CC_ENTRYTRACKER_fillCount
   );

   modport slave (
      input  CC_ENTRYTRACKER_clear_InHigh,
      input  CC_ENTRYTRACKER_check_InHigh,
      input  CC_ENTRYTRACKER_entryBUS,
      input  CC_ENTRYTRACKER_froggerBUS,
      output CC_ENTRYTRACKER_enter_OutLow,
      output CC_ENTRYTRACKER_lose_OutLow,
      output CC_ENTRYTRACKER_win_OutLow,
      output CC_ENTRYTRACKER_gameover_OutLow,
      output CC_ENTRYTRACKER_filledBUS,
      output CC_ENTRYTRACKER_fillCount
   );

endinterface

// File: rtl/cc_entry_tracker_lives.sv
// cc_entry_lives_counter
//   Lives down-counter, preset to LIVES on reset or load, saturating at 0.
//   clk_sys : system clock
//   rst     : synchronous reset, active-high (presets to LIVES)
//   load    : restore LIVES (round clear)
//   dec     : take one life
//   count   : lives remaining
//   zero    : no lives remaining
module cc_entry_lives_counter
   import cc_entry_tracker_pkg::*;
#(
   parameter  int LIVES = 3,
   localparam int LW    = count_width(LIVES)
) (
   input  logic          clk_sys,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   output logic [LW-1:0] count,
   output logic          zero
);

   logic [LW-1:0] count_q;
   logic [LW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = LW'(LIVES);
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - LW'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         count_q <= LW'(LIVES);
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/cc_entry_tracker.sv
// cc_entry_tracker
//   Goal-row judge for Frogger. On a check strobe the frog column is judged
//   against the open-entry mask and the occupied mask; enter/lose pulse one
//   cycle later, filledBUS/fillCount/state update on that same edge.
//   Optional macro CC_ENTRYTRACKER_LIVES_EN adds a lives counter and the
//   OVER state; without it gameover_OutLow is tied high.
//   CC_ENTRYTRACKER_CLOCK_50     : system clock
//   CC_ENTRYTRACKER_RESET_InHigh : synchronous reset, active-high
//   bus                          : cc_entry_tracker_if.slave (see interface)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   PLAY  | round running, checks are judged
//   WON   | every open entry filled; win held low, checks ignored
//   OVER  | lives exhausted; gameover held low, checks ignored
module cc_entry_tracker
   import cc_entry_tracker_pkg::*;
#(
   parameter int ENTRYTRACKER_DATAWIDTH = 8,
   parameter int ENTRYTRACKER_LIVES     = 3
) (
   input  logic                 CC_ENTRYTRACKER_CLOCK_50,
   input  logic                 CC_ENTRYTRACKER_RESET_InHigh,
   cc_entry_tracker_if.slave    bus
);

   localparam int DW = ENTRYTRACKER_DATAWIDTH;
   localparam int CW = count_width(DW);

   logic          clk_sys;
   logic          rst;
   logic          clear;
   logic          check;
   logic [DW-1:0] entry;
   logic [DW-1:0] frog;

   state_e        state_q, state_d;
   logic [DW-1:0] filled_q, filled_d;
   logic [CW-1:0] fill_count_q, fill_count_d;
   logic          enter_n_q, enter_n_d;
   logic          lose_n_q, lose_n_d;

   logic [DW-1:0] hit;
   logic [DW-1:0] occ;
   logic          wall;
   logic          judge;
   result_e       result;
   logic          lives_last;

   assign clk_sys = CC_ENTRYTRACKER_CLOCK_50;
   assign rst     = CC_ENTRYTRACKER_RESET_InHigh;
   assign clear   = bus.CC_ENTRYTRACKER_clear_InHigh;
   assign check   = bus.CC_ENTRYTRACKER_check_InHigh;
   assign entry   = bus.CC_ENTRYTRACKER_entryBUS;
   assign frog    = bus.CC_ENTRYTRACKER_froggerBUS;

   assign hit  = frog & entry & ~filled_q;
   assign occ  = frog & filled_q;
   assign wall = ((frog & entry) == '0);

   // clear wins over a coincident check, so the check is never judged
   assign judge = check && !clear && (state_q == PLAY) && (|entry) && (|frog);

   // Any hit bit makes the whole (possibly multi-hot) check an enter.
   always_comb begin
      result = RES_NONE;
      if (judge) begin
         if (|hit) begin
            result = RES_ENTER;
         end else if ((|occ) || wall) begin
            result = RES_LOSE;
         end
      end
   end

`ifdef CC_ENTRYTRACKER_LIVES_EN
   localparam int LW = count_width(ENTRYTRACKER_LIVES);

   logic [LW-1:0] lives_count;
   logic          lives_zero;

   cc_entry_lives_counter #(
      .LIVES (ENTRYTRACKER_LIVES)
   ) u_lives (
      .clk_sys (clk_sys),
      .rst     (rst),
      .load    (clear),
      .dec     (result == RES_LOSE),
      .count   (lives_count),
      .zero    (lives_zero)
   );

   // this lose takes the count to zero (or it is already there)
   assign lives_last = lives_zero || (lives_count == LW'(1));
`else
   logic unused_lives;
   assign unused_lives = (ENTRYTRACKER_LIVES != 0);
   assign lives_last   = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      filled_d  = filled_q;
      enter_n_d = 1'b1;
      lose_n_d  = 1'b1;
      if (clear) begin
         state_d  = PLAY;
         filled_d = '0;
      end else begin
         case (result)
            RES_ENTER: begin
               filled_d  = filled_q | hit;
               enter_n_d = 1'b0;
            end
            RES_LOSE: begin
               lose_n_d = 1'b0;
               if (lives_last) begin
                  state_d = OVER;
               end
            end
            default: ;
         endcase
         // Stale filled bits outside the current mask are masked off here.
         if ((result != RES_NONE) && ((filled_d & entry) == entry)) begin
            state_d = WON;
         end
      end
   end

   always_comb begin
      fill_count_d = '0;
      for (int i = 0; i < DW; i++) begin
         fill_count_d = fill_count_d + CW'(filled_d[i]);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q      <= PLAY;
         filled_q     <= '0;
         fill_count_q <= '0;
         enter_n_q    <= 1'b1;
         lose_n_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         filled_q     <= filled_d;
         fill_count_q <= fill_count_d;
         enter_n_q    <= enter_n_d;
         lose_n_q     <= lose_n_d;
      end
   end

   assign bus.CC_ENTRYTRACKER_enter_OutLow = enter_n_q;
   assign bus.CC_ENTRYTRACKER_lose_OutLow  = lose_n_q;
   assign bus.CC_ENTRYTRACKER_win_OutLow   = (state_q != WON);
   assign bus.CC_ENTRYTRACKER_filledBUS    = filled_q;
   assign bus.CC_ENTRYTRACKER_fillCount    = fill_count_q;
`ifdef CC_ENTRYTRACKER_LIVES_EN
   assign bus.CC_ENTRYTRACKER_gameover_OutLow = (state_q != OVER);
`else
   assign bus.CC_ENTRYTRACKER_gameover_OutLow = 1'b1;
`endif

endmodule

// File: tb/tb_cc_entry_tracker.sv
// tb_cc_entry_tracker
//   Bench for cc_entry_tracker (DW=8, LIVES=3). A per-column reference model
//   tracks occupied entries, lives and round state; every cycle the bench
//   compares {enter, lose, win, gameover, filledBUS, fillCount} to it.
module tb_cc_entry_tracker;

   localparam int DW    = 8;
   localparam int LIVES = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cc_entry_tracker_if #(.DW(DW)) bus ();

   cc_entry_tracker #(
      .ENTRYTRACKER_DATAWIDTH (DW),
      .ENTRYTRACKER_LIVES     (LIVES)
   ) dut (
      .CC_ENTRYTRACKER_CLOCK_50     (clk),
      .CC_ENTRYTRACKER_RESET_InHigh (rst),
      .bus                          (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: state 0=playing, 1=won, 2=over
   bit [DW-1:0] m_filled;
   int          m_state;
   int          m_lives;
   bit          m_enter_n;
   bit          m_lose_n;

   function automatic logic [15:0] exp_vec();
      int  cnt;
      bit  go_n;
      cnt = 0;
      for (int i = 0; i < DW; i++) if (m_filled[i]) cnt++;
`ifdef CC_ENTRYTRACKER_LIVES_EN
      go_n = (m_state != 2);
`else
      go_n = 1'b1;
`endif
      return {m_enter_n, m_lose_n, (m_state != 1), go_n, m_filled, 4'(cnt)};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {bus.CC_ENTRYTRACKER_enter_OutLow, bus.CC_ENTRYTRACKER_lose_OutLow,
              bus.CC_ENTRYTRACKER_win_OutLow, bus.CC_ENTRYTRACKER_gameover_OutLow,
              bus.CC_ENTRYTRACKER_filledBUS, bus.CC_ENTRYTRACKER_fillCount};
   endfunction

   // Drive one cycle of inputs, advance the model, then sample after the edge.
   task automatic tick(input bit clr, input bit chk, input logic [DW-1:0] ent,
                       input logic [DW-1:0] frog);
      int hits;
      @(negedge clk);
      bus.CC_ENTRYTRACKER_clear_InHigh = clr;
      bus.CC_ENTRYTRACKER_check_InHigh = chk;
      bus.CC_ENTRYTRACKER_entryBUS     = ent;
      bus.CC_ENTRYTRACKER_froggerBUS   = frog;
      m_enter_n = 1'b1;
      m_lose_n  = 1'b1;
      hits      = 0;
      if (rst || clr) begin
         m_filled = '0;
         m_state  = 0;
         m_lives  = LIVES;
      end else if (chk && m_state == 0 && ent != 0 && frog != 0) begin
         for (int i = 0; i < DW; i++) begin
            if (frog[i] && ent[i] && !m_filled[i]) begin
               hits++;
               m_filled[i] = 1'b1;
            end
         end
         if (hits > 0) begin
            m_enter_n = 1'b0;
         end else begin
            m_lose_n = 1'b0;
`ifdef CC_ENTRYTRACKER_LIVES_EN
            if (m_lives > 0) m_lives--;
            if (m_lives == 0) m_state = 2;
`endif
         end
         if ((m_filled & ent) == ent) m_state = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(0, 0, '0, '0);
      tick(0, 1, 8'h49, 8'h08);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 8'h49, '0);
         checks++;
         if (obs_vec() !== 16'hF000) begin
            failures++;
            $display("FAIL reset_idle obs=%h exp=%h", obs_vec(), 16'hF000);
         end
      end
   endtask

   task automatic test_enter();
      tick(0, 1, 8'h49, 8'h08);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL enter_model obs=%h exp=%h", obs_vec(), exp_vec());
      end
      checks++;
      if ({bus.CC_ENTRYTRACKER_enter_OutLow, bus.CC_ENTRYTRACKER_filledBUS,
           bus.CC_ENTRYTRACKER_fillCount} !== {1'b0, 8'h08, 4'd1}) begin
         failures++;
         $display("FAIL enter_const enter=%b filled=%h count=%0d exp 0/08/1",
                  bus.CC_ENTRYTRACKER_enter_OutLow, bus.CC_ENTRYTRACKER_filledBUS,
                  bus.CC_ENTRYTRACKER_fillCount);
      end
      tick(0, 0, 8'h49, 8'h08);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL enter_one_cycle obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_lose();
      tick(0, 1, 8'h49, 8'h08);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_lose_OutLow !== 1'b0) begin
         failures++;
         $display("FAIL lose_occupied obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(0, 1, 8'h49, 8'h02);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_filledBUS !== 8'h08) begin
         failures++;
         $display("FAIL lose_wall obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(0, 0, 8'h49, 8'h02);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL lose_one_cycle obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_win();
      tick(0, 1, 8'h49, 8'h01);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL win_fill0 obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(0, 1, 8'h49, 8'h40);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_enter_OutLow !== 1'b0
          || bus.CC_ENTRYTRACKER_win_OutLow !== 1'b0) begin
         failures++;
         $display("FAIL win_last_fill obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(0, 1, 8'h49, 8'h02);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_win_OutLow !== 1'b0) begin
         failures++;
         $display("FAIL win_held_ignore obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(1, 0, 8'h49, '0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_filledBUS !== 8'h00) begin
         failures++;
         $display("FAIL win_clear obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_lives();
      bit go_exp;
      tick(1, 0, 8'h49, '0);
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 8'h49, 8'h02);
         checks++;
         if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_lose_OutLow !== 1'b0) begin
            failures++;
            $display("FAIL lives_wall%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
`ifdef CC_ENTRYTRACKER_LIVES_EN
      go_exp = 1'b0;
`else
      go_exp = 1'b1;
`endif
      tick(0, 1, 8'h49, 8'h08);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_gameover_OutLow !== go_exp) begin
         failures++;
         $display("FAIL lives_gameover obs=%h exp=%h go=%b", obs_vec(), exp_vec(), go_exp);
      end
      tick(1, 0, 8'h49, '0);
   endtask

   task automatic test_ignored();
      tick(0, 1, 8'h49, 8'h08);
      tick(1, 1, 8'h49, 8'h01);
      checks++;
      if (obs_vec() !== exp_vec() || obs_vec() !== 16'hF000) begin
         failures++;
         $display("FAIL clear_and_check obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(0, 1, 8'h49, 8'h01);
      tick(0, 1, 8'h00, 8'h08);
      checks++;
      if (obs_vec() !== exp_vec() || bus.CC_ENTRYTRACKER_filledBUS !== 8'h01) begin
         failures++;
         $display("FAIL entry_zero obs=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(0, 1, 8'h49, 8'h00);
      checks++;
      if (obs_vec() !== exp_vec() || obs_vec() !== 16'hF011) begin
         failures++;
         $display("FAIL frog_zero obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] frogs [4] = '{8'h01, 8'h08, 8'h08, 8'h09};
      tick(1, 0, 8'h49, '0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 8'h49, frogs[i]);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL back_to_back%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] ent;
      logic [DW-1:0] frog;
      bit            clr;
      bit            chk;
      tick(1, 0, 8'h49, '0);
      for (int n = 0; n < 600; n++) begin
         clr = ($urandom_range(0, 29) == 0);
         chk = ($urandom_range(0, 1) == 1);
         ent = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom & $urandom);
         case ($urandom_range(0, 9))
            0:       frog = '0;
            1, 2:    frog = DW'($urandom);
            default: frog = DW'(1) << $urandom_range(0, DW - 1);
         endcase
         tick(clr, chk, ent, frog);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random%0d obs=%h exp=%h ent=%h frog=%h", n, obs_vec(),
                     exp_vec(), ent, frog);
         end
      end
   endtask

   initial begin
      bus.CC_ENTRYTRACKER_clear_InHigh = 1'b0;
      bus.CC_ENTRYTRACKER_check_InHigh = 1'b0;
      bus.CC_ENTRYTRACKER_entryBUS     = '0;
      bus.CC_ENTRYTRACKER_froggerBUS   = '0;
      m_filled  = '0;
      m_state   = 0;
      m_lives   = LIVES;
      m_enter_n = 1'b1;
      m_lose_n  = 1'b1;
      test_reset();
      test_enter();
      test_lose();
      test_win();
      test_lives();
      test_ignored();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
